// File: rtl/gf2_rref_reducer.sv
// Sequential Gauss-Jordan eliminator over GF(2).
// Reduces an augmented matrix one variable column at a time, then aligns pivot rows
// so that RREF row c belongs to variable c, and flags free variables and inconsistency.
module gf2_rref_reducer #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [COLS-1:0] A [ROWS],
    output logic [COLS-1:0] RREF [COLS-1],
    output logic [COLS-2:0] free_mask,
    output logic            inconsistent,
    output logic            busy,
    output logic            done
);

    localparam int unsigned VARS = COLS - 1;
    localparam int unsigned ColW = $clog2(COLS);
    localparam int unsigned PrW  = $clog2(ROWS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StPivot,
        StElim,
        StAlign,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [COLS-1:0]     w_q [ROWS];
    logic [COLS-1:0]     w_d [ROWS];
    logic [ColW-1:0]     col_q, col_d;
    logic [PrW-1:0]      pr_q, pr_d;
    logic [VARS-1:0]     free_q, free_d;     // indexed by variable number
    logic [PrW-1:0]      piv_q [VARS];
    logic [PrW-1:0]      piv_d [VARS];
    logic [COLS-1:0]     rref_q [VARS];
    logic [COLS-1:0]     rref_d [VARS];
    logic [VARS-1:0]     fm_q, fm_d;
    logic                inc_q, inc_d;

    logic [ColW-1:0]     bsel;
    logic                found;
    logic [PrW-1:0]      sel;
    logic [COLS-1:0]     pr_row;
    logic [COLS-1:0]     sel_row;
    logic                last_col;

    // Bit position of the current variable column inside a row.
    assign bsel     = ColW'(COLS - 1) - col_q;
    assign last_col = (col_q == ColW'(VARS - 1));

    // Lowest row at or below pr with a one in the current column; empty once pr == ROWS.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if ((PrW'(r) >= pr_q) && w_q[r][bsel]) begin
                found = 1'b1;
                sel   = PrW'(r);
            end
        end
    end

    // Row multiplexers for the current pivot slot and the selected candidate row.
    always_comb begin
        pr_row  = '0;
        sel_row = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (PrW'(r) == pr_q) pr_row = w_q[r];
            if (PrW'(r) == sel)  sel_row = w_q[r];
        end
    end

    // Next-state logic and control outputs.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        col_d   = col_q;
        pr_d    = pr_q;
        free_d  = free_q;
        piv_d   = piv_q;
        rref_d  = rref_q;
        fm_d    = fm_q;
        inc_d   = inc_q;
        busy    = (state_q != StIdle);
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int r = 0; r < int'(ROWS); r++) w_d[r] = A[r];
                    col_d   = '0;
                    pr_d    = '0;
                    free_d  = '0;
                    state_d = StPivot;
                end
            end

            StPivot: begin
                if (!found) begin
                    for (int c = 0; c < int'(VARS); c++) begin
                        if (ColW'(c) == col_q) free_d[c] = 1'b1;
                    end
                    col_d   = col_q + ColW'(1);
                    state_d = last_col ? StAlign : StPivot;
                end else begin
                    // Swap candidate into the pivot slot; harmless when sel == pr.
                    for (int r = 0; r < int'(ROWS); r++) begin
                        if (PrW'(r) == pr_q) w_d[r] = sel_row;
                        if (PrW'(r) == sel)  w_d[r] = pr_row;
                    end
                    state_d = StElim;
                end
            end

            StElim: begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    if ((PrW'(r) != pr_q) && w_q[r][bsel]) w_d[r] = w_q[r] ^ pr_row;
                end
                for (int c = 0; c < int'(VARS); c++) begin
                    if (ColW'(c) == col_q) piv_d[c] = pr_q;
                end
                pr_d    = pr_q + PrW'(1);
                col_d   = col_q + ColW'(1);
                state_d = last_col ? StAlign : StPivot;
            end

            StAlign: begin
                for (int c = 0; c < int'(VARS); c++) begin
                    rref_d[c] = '0;
                    if (!free_q[c]) begin
                        for (int r = 0; r < int'(ROWS); r++) begin
                            if (PrW'(r) == piv_q[c]) rref_d[c] = w_q[r];
                        end
                    end
                    fm_d[VARS-1-c] = free_q[c];
                end
                // Rows past the rank have zero variable bits; any RHS one is a contradiction.
                inc_d = 1'b0;
                for (int r = 0; r < int'(ROWS); r++) begin
                    if (PrW'(r) >= pr_q) inc_d = inc_d | w_q[r][0];
                end
                state_d = StDone;
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, working matrix and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            pr_q    <= '0;
            free_q  <= '0;
            fm_q    <= '0;
            inc_q   <= 1'b0;
            for (int r = 0; r < int'(ROWS); r++) w_q[r] <= '0;
            for (int c = 0; c < int'(VARS); c++) begin
                piv_q[c]  <= '0;
                rref_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            pr_q    <= pr_d;
            free_q  <= free_d;
            fm_q    <= fm_d;
            inc_q   <= inc_d;
            for (int r = 0; r < int'(ROWS); r++) w_q[r] <= w_d[r];
            for (int c = 0; c < int'(VARS); c++) begin
                piv_q[c]  <= piv_d[c];
                rref_q[c] <= rref_d[c];
            end
        end
    end

    // Registered results drive the outputs directly.
    always_comb begin
        for (int c = 0; c < int'(VARS); c++) RREF[c] = rref_q[c];
        free_mask    = fm_q;
        inconsistent = inc_q;
    end

endmodule

// File: tb/tb_gf2_rref_reducer.sv
// Self-checking bench: four reducer instances of different sizes, a per-cycle compare
// against a behavioural Gauss-Jordan model, and literal checks from hand-solved systems.
module tb_gf2_rref_reducer;

    typedef logic [2:0][3:0] mat_t;   // up to 3 rows of up to 4 bits, row i at [i]
    typedef struct packed {
        mat_t       rref;
        logic [2:0] fm;
        logic       inc;
        logic [7:0] n;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    mat_t [3:0]       a_in;
    logic [3:0]       start_in;
    mat_t [3:0]       o_rref;
    logic [3:0][2:0]  o_fm;
    logic [3:0]       o_inc, o_busy, o_done;

    res_t run [4];
    res_t vis [4];
    logic active [4];
    int   t [4];

    always #5 clk = ~clk;

    // DUT 0: COLS=4, ROWS=2
    logic [3:0] a0 [2];
    logic [3:0] r0 [3];
    logic [2:0] fm0;
    assign a0[0] = a_in[0][0];
    assign a0[1] = a_in[0][1];
    gf2_rref_reducer #(.ROWS(2), .COLS(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start_in[0]), .A(a0), .RREF(r0),
        .free_mask(fm0), .inconsistent(o_inc[0]), .busy(o_busy[0]), .done(o_done[0])
    );
    assign o_rref[0] = {r0[2], r0[1], r0[0]};
    assign o_fm[0]   = fm0;

    // DUT 1: COLS=3, ROWS=2
    logic [2:0] a1 [2];
    logic [2:0] r1 [2];
    logic [1:0] fm1;
    assign a1[0] = a_in[1][0][2:0];
    assign a1[1] = a_in[1][1][2:0];
    gf2_rref_reducer #(.ROWS(2), .COLS(3)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_in[1]), .A(a1), .RREF(r1),
        .free_mask(fm1), .inconsistent(o_inc[1]), .busy(o_busy[1]), .done(o_done[1])
    );
    assign o_rref[1] = {4'b0000, 1'b0, r1[1], 1'b0, r1[0]};
    assign o_fm[1]   = {1'b0, fm1};

    // DUT 2: COLS=3, ROWS=3
    logic [2:0] a2 [3];
    logic [2:0] r2 [2];
    logic [1:0] fm2;
    assign a2[0] = a_in[2][0][2:0];
    assign a2[1] = a_in[2][1][2:0];
    assign a2[2] = a_in[2][2][2:0];
    gf2_rref_reducer #(.ROWS(3), .COLS(3)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_in[2]), .A(a2), .RREF(r2),
        .free_mask(fm2), .inconsistent(o_inc[2]), .busy(o_busy[2]), .done(o_done[2])
    );
    assign o_rref[2] = {4'b0000, 1'b0, r2[1], 1'b0, r2[0]};
    assign o_fm[2]   = {1'b0, fm2};

    // DUT 3: COLS=4, ROWS=3
    logic [3:0] a3 [3];
    logic [3:0] r3 [3];
    logic [2:0] fm3;
    assign a3[0] = a_in[3][0];
    assign a3[1] = a_in[3][1];
    assign a3[2] = a_in[3][2];
    gf2_rref_reducer #(.ROWS(3), .COLS(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start_in[3]), .A(a3), .RREF(r3),
        .free_mask(fm3), .inconsistent(o_inc[3]), .busy(o_busy[3]), .done(o_done[3])
    );
    assign o_rref[3] = {r3[2], r3[1], r3[0]};
    assign o_fm[3]   = fm3;

    function automatic int rows_of(int k);
        return (k < 2) ? 2 : 3;
    endfunction

    function automatic int cols_of(int k);
        return (k == 1 || k == 2) ? 3 : 4;
    endfunction

    function automatic mat_t pk3(logic [3:0] x0, logic [3:0] x1, logic [3:0] x2);
        return {x2, x1, x0};
    endfunction

    // Plain Gauss-Jordan elimination on a row array, variable c at bit cols-1-c.
    function automatic res_t model(int rows, int cols, mat_t a);
        res_t       res;
        logic [3:0] m [3];
        logic [3:0] tmp;
        int         piv [3];
        int         pr, vars, sel, b;
        res  = '0;
        vars = cols - 1;
        pr   = 0;
        for (int r = 0; r < 3; r++) m[r] = (r < rows) ? a[r] : 4'b0000;
        for (int c = 0; c < vars; c++) begin
            b   = cols - 1 - c;
            sel = -1;
            for (int r = rows - 1; r >= pr; r--) if (m[r][b]) sel = r;
            if (sel < 0) begin
                res.fm[vars-1-c] = 1'b1;
                piv[c] = -1;
            end else begin
                tmp = m[sel]; m[sel] = m[pr]; m[pr] = tmp;
                for (int r = 0; r < rows; r++) if (r != pr && m[r][b]) m[r] = m[r] ^ m[pr];
                piv[c] = pr;
                pr++;
            end
        end
        for (int r = pr; r < rows; r++) res.inc = res.inc | m[r][0];
        for (int c = 0; c < vars; c++) res.rref[c] = (piv[c] < 0) ? 4'b0000 : m[piv[c]];
        res.n = 8'(2 * pr + vars - pr);
        return res;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model bookkeeping: tracks which cycle of a run each instance is in.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                active[k] = 1'b0;
                t[k]      = 0;
                vis[k]    = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if ((!active[k] || t[k] >= int'(run[k].n) + 3) && start_in[k]) begin
                    run[k]    = model(rows_of(k), cols_of(k), a_in[k]);
                    active[k] = 1'b1;
                    t[k]      = 1;
                end else if (active[k]) begin
                    t[k]++;
                    if (t[k] == int'(run[k].n) + 2) vis[k] = run[k];
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                logic eb, ed;
                eb = active[k] && (t[k] <= int'(run[k].n) + 2);
                ed = active[k] && (t[k] == int'(run[k].n) + 2);
                check($sformatf("cycle dut%0d t=%0d", k, t[k]),
                      32'({o_busy[k], o_done[k], o_inc[k], o_fm[k], o_rref[k]}),
                      32'({eb, ed, vis[k].inc, vis[k].fm, vis[k].rref}));
            end
        end
    end

    task automatic start_case(int k, mat_t a, int hold);
        @(negedge clk);
        #1;
        a_in[k]     = a;
        start_in[k] = 1'b1;
        @(posedge clk);
        repeat (hold) @(posedge clk);
        #1;
        start_in[k] = 1'b0;
    endtask

    // Runs to a fixed cycle so stray extra pulses are counted too.
    task automatic wait_done(int k, int first_cyc, int last_cyc, output int dc, output int np);
        dc = 0;
        np = 0;
        for (int cyc = first_cyc; cyc <= last_cyc; cyc++) begin
            @(negedge clk);
            if (o_done[k]) begin
                np++;
                if (dc == 0) dc = cyc;
            end
        end
    endtask

    task automatic check_out(string name, int k, mat_t rref, logic [2:0] fm, logic inc);
        check({name, " rref"}, 32'(o_rref[k]), 32'(rref));
        check({name, " free_mask"}, 32'(o_fm[k]), 32'(fm));
        check({name, " inconsistent"}, 32'(o_inc[k]), 32'(inc));
    endtask

    initial begin
        int dc, np;
        a_in     = '0;
        start_in = '0;
        for (int k = 0; k < 4; k++) begin
            active[k] = 1'b0;
            t[k]      = 0;
            vis[k]    = '0;
            run[k]    = '0;
        end
        #12;
        chk_en = 1'b1;
        check("reset busy", 32'(o_busy), 32'(0));
        check_out("reset", 3, pk3(4'h0, 4'h0, 4'h0), 3'b000, 1'b0);
        #10;
        rst_n = 1'b1;

        // Chain case; A is scribbled after the start edge and must be ignored.
        start_case(0, pk3(4'b1101, 4'b0111, 4'b0000), 0);
        a_in[0] = '1;
        wait_done(0, 1, 20, dc, np);
        check("chain done cycle", 32'(dc), 32'(7));
        check("chain pulses", 32'(np), 32'(1));
        check_out("chain", 0, pk3(4'b1010, 4'b0111, 4'b0000), 3'b001, 1'b0);

        // Inconsistent system.
        start_case(1, pk3(4'b0101, 4'b0100, 4'b0000), 0);
        wait_done(1, 1, 15, dc, np);
        check("incons done cycle", 32'(dc), 32'(5));
        check_out("incons", 1, pk3(4'b0101, 4'b0000, 4'b0000), 3'b001, 1'b1);

        // Dependent rows needing a swap.
        start_case(2, pk3(4'b0110, 4'b0110, 4'b0011), 0);
        wait_done(2, 1, 15, dc, np);
        check("dep done cycle", 32'(dc), 32'(6));
        check_out("dep", 2, pk3(4'b0101, 4'b0011, 4'b0000), 3'b000, 1'b0);

        // Identity with start held high through cycle 7.
        start_case(3, pk3(4'b1001, 4'b0100, 4'b0011), 7);
        check("ident busy held", 32'(o_busy[3]), 32'(1));
        wait_done(3, 8, 25, dc, np);
        check("ident done cycle", 32'(dc), 32'(8));
        check("ident pulses", 32'(np), 32'(1));
        check_out("ident", 3, pk3(4'b1001, 4'b0100, 4'b0011), 3'b000, 1'b0);

        // Abort the chain case in cycle 3.
        start_case(0, pk3(4'b1101, 4'b0111, 4'b0000), 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(o_busy[0]), 32'(0));
        check("abort done", 32'(o_done[0]), 32'(0));
        check_out("abort", 0, pk3(4'h0, 4'h0, 4'h0), 3'b000, 1'b0);
        #2;
        rst_n = 1'b1;
        wait_done(0, 1, 15, dc, np);
        check("abort no pulse", 32'(np), 32'(0));
        start_case(0, pk3(4'b1101, 4'b0111, 4'b0000), 0);
        wait_done(0, 1, 15, dc, np);
        check("rerun done cycle", 32'(dc), 32'(7));
        check_out("rerun", 0, pk3(4'b1010, 4'b0111, 4'b0000), 3'b001, 1'b0);

        // All-zero matrix, then a lone RHS one.
        start_case(3, pk3(4'b0000, 4'b0000, 4'b0000), 0);
        wait_done(3, 1, 12, dc, np);
        check("zero done cycle", 32'(dc), 32'(5));
        check_out("zero", 3, pk3(4'h0, 4'h0, 4'h0), 3'b111, 1'b0);
        start_case(3, pk3(4'b0000, 4'b0000, 4'b0001), 0);
        wait_done(3, 1, 12, dc, np);
        check("zero rhs done cycle", 32'(dc), 32'(5));
        check_out("zero rhs", 3, pk3(4'h0, 4'h0, 4'h0), 3'b111, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gf2_rref_reducer.md
Name: gf2_rref_reducer

Overview:
- Sequential Gauss-Jordan eliminator over GF(2). Sits directly upstream of the solution enumerator.
- Takes an augmented equation matrix and produces a diagonal-aligned reduced row echelon matrix, a free-variable mask and an inconsistency flag.
- Its RREF output connects straight to the enumerator's RREF input; the enumerator is instantiated with ROWS = COLS-1.

Parameters:
- ROWS, 8, number of input equations (rows of the augmented matrix); >= 1.
- COLS, 8, bits per row = variable count + 1; >= 2. VARS = COLS-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin reduction; sampled only in IDLE.
- A  input  [COLS-1:0] x ROWS  augmented equations. Variable c coefficient is at bit COLS-1-c; the right-hand side is bit 0.
- RREF  output  [COLS-1:0] x VARS  aligned result. Row c holds the pivot row of variable c, or all zero if variable c is free.
- free_mask  output  VARS  bit VARS-1-c set iff variable c is free.
- inconsistent  output  1  system has no solution.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the outputs become valid.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - RREF, free_mask, inconsistent, done, busy = 0.
  - Working rows, column index and pivot-row counter pr cleared.
- Asserting reset mid-run aborts immediately. No done pulse is produced; the next start begins clean.
- States: IDLE, PIVOT, ELIM, ALIGN, DONE.
- IDLE:
  - On start=1 at a clock edge, capture A into working rows W[0..ROWS-1]; set col=0, pr=0; go to PIVOT.
  - start while not IDLE is ignored.
- PIVOT (one variable column, bit b = COLS-1-col):
  - If pr == ROWS, or no row r >= pr has W[r][b]=1: mark col free; col++. Go to ALIGN if col was VARS-1, else stay in PIVOT. Costs 1 cycle.
  - Otherwise pick the lowest such r and swap W[r] with W[pr] (no-op if r == pr); go to ELIM.
- ELIM (1 cycle):
  - Every row r != pr with W[r][b]=1 gets W[r] ^= W[pr].
  - Record pivot_row[col] = pr; pr++; col++.
  - Go to ALIGN after the last column, else PIVOT.
- Column phase length: N = 2*rank + (VARS - rank) cycles.
- ALIGN (1 cycle), registered at exit:
  - RREF[c] = W[pivot_row[c]] for pivot columns, 0 for free columns.
  - free_mask set from the free marks.
  - inconsistent = OR over rows r >= rank of W[r][0]. Those rows have all-zero variable bits.
  - Go to DONE.
- DONE (1 cycle): done=1; go to IDLE.
- Latency: start-sampling edge = cycle 0. Column states occupy cycles 1..N, ALIGN is cycle N+1, done=1 during cycle N+2.
- Input rows beyond rank are discarded: duplicate or dependent equations vanish; only their RHS feeds inconsistent.
- When ROWS < VARS, at least VARS-ROWS variables are free. Pivot search stops once pr == ROWS.
- RREF, free_mask and inconsistent hold stable from done until the next start is accepted. They are cleared only by reset, never by start.
- RREF is valid when inconsistent=1, but the consumer must not be started.
- A is sampled only at the start edge. Later changes to A have no effect.

Test Plan:
- Chain case: COLS=4, ROWS=2, A = {4'b1101, 4'b0111} -> done in cycle 7 (N=5).
  - RREF = {4'b1010, 4'b0111, 4'b0000} for variables 0, 1, 2.
  - free_mask = 3'b001, inconsistent = 0.
- Inconsistent system: COLS=3, ROWS=2, A = {3'b101, 3'b100} -> N=3, done in cycle 5.
  - RREF = {3'b101, 3'b000}, free_mask = 2'b01, inconsistent = 1.
- Dependent rows with swap: COLS=3, ROWS=3, A = {3'b110, 3'b110, 3'b011} -> N=4, done in cycle 6.
  - RREF = {3'b101, 3'b011}, free_mask = 2'b00, inconsistent = 0.
- Identity: COLS=4, ROWS=3, A = {4'b1001, 4'b0100, 4'b0011} -> RREF equals A, free_mask = 0, done in cycle 8.
  - start held high during cycles 1..7 is ignored and busy stays 1.
  - Exactly one done pulse is produced.
- Abort: drop rst_n during cycle 3 of the chain case -> all outputs are 0 while reset is held, and no done pulse appears.
  - A new start afterwards reproduces the chain-case result exactly.
- All-zero A (COLS=4, ROWS=3) -> N=3, RREF all zero, free_mask = 3'b111, inconsistent = 0.
  - Repeat with A[2] = 4'b0001 -> inconsistent = 1.
